// File: rtl/poly_fit_sequencer.sv
// rtl/poly_fit_sequencer.sv - frame collector, fit-engine launcher and coefficient drainer
module poly_fit_sequencer #(
  parameter int N       = 10,
  parameter int DEGREE  = 5,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [W-1:0]                s_x,
  input  logic [W-1:0]                s_y,
  output logic                        fit_start,
  input  logic                        fit_done,
  input  logic [$clog2(N)-1:0]        buf_addr,
  output logic [W-1:0]                buf_x,
  output logic [W-1:0]                buf_y,
  output logic [$clog2(DEGREE+1)-1:0] fit_coef_idx,
  input  logic [W-1:0]                fit_coef,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [W-1:0]                m_coef,
  output logic [$clog2(DEGREE+1)-1:0] m_idx,
  output logic                        m_last,
  output logic                        err_timeout,
  output logic [15:0]                 frame_count
);

  localparam int AW    = $clog2(N);
  localparam int IW    = $clog2(DEGREE + 1);
  localparam int CW    = $clog2(TIMEOUT) + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, FILL, START, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic [W-1:0]  buf_x_q [DEPTH];
  logic [W-1:0]  buf_y_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  // Control registers; reset discards any partial frame or drain in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sample buffer; only written while collecting, so it is stable for the engine.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_x_q[wr_addr] <= s_x;
      buf_y_q[wr_addr] <= s_y;
    end
  end

  // Next-state and handshake logic for collect, launch, wait and drain phases.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    err_d         = err_q;
    frame_count_d = frame_count_q;
    s_ready       = 1'b0;
    fit_start     = 1'b0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr_q;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        wr_addr = '0;
        if (s_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = AW'(1);
          err_d    = 1'b0;
          state_d  = FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(N - 1)) state_d = START;
        end
      end
      START: begin
        fit_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving on the expiry cycle still wins over the abort.
        if (fit_done) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (idx_q == IW'(DEGREE));
        if (m_ready) begin
          if (m_last) begin
            idx_d         = '0;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign buf_x        = buf_x_q[buf_addr];
  assign buf_y        = buf_y_q[buf_addr];
  assign fit_coef_idx = idx_q;
  assign m_idx        = idx_q;
  assign m_coef       = fit_coef;
  assign err_timeout  = err_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_poly_fit_sequencer.sv
// tb/tb_poly_fit_sequencer.sv - randomized model-checked bench for poly_fit_sequencer
module tb_poly_fit_sequencer;
  localparam int N = 4, DEGREE = 2, W = 32, TIMEOUT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, s_valid, s_ready, fit_start, fit_done, m_valid, m_ready, m_last, err_timeout;
  logic [W-1:0] s_x, s_y, buf_x, buf_y, fit_coef, m_coef;
  logic [1:0] buf_addr, fit_coef_idx, m_idx;
  logic [15:0] frame_count;
  logic [W-1:0] coef_mem [4];

  assign fit_coef = coef_mem[fit_coef_idx];

  poly_fit_sequencer #(.N(N), .DEGREE(DEGREE), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .fit_start(fit_start), .fit_done(fit_done), .buf_addr(buf_addr), .buf_x(buf_x), .buf_y(buf_y),
    .fit_coef_idx(fit_coef_idx), .fit_coef(fit_coef), .m_valid(m_valid), .m_ready(m_ready),
    .m_coef(m_coef), .m_idx(m_idx), .m_last(m_last), .err_timeout(err_timeout),
    .frame_count(frame_count)
  );

  // reference model: phase 0 collecting, 1 launching, 2 engine busy, 3 emitting
  int ph, nsamp, wcnt, midx;
  bit merr, frame_end;
  logic [15:0] mfc;
  logic [W-1:0] mx [4];
  logic [W-1:0] my [4];

  // stimulus knobs
  int p_valid, p_ready, p_spur, done_at;
  bit sweep;
  logic [W-1:0] dq_x[$], dq_y[$];
  int rq[$];

  // observations of the DUT
  int cyc, t_start, t_err, n_start, n_mvalid;
  bit prev_err;
  logic [W-1:0] o_coef[$];
  int o_idx[$];
  bit o_last[$];
  logic [W-1:0] bx [4];
  logic [W-1:0] by [4];
  logic [W-1:0] yexp [4];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    s_valid = (int'($urandom_range(0, 99)) < p_valid);
    s_x = $urandom;
    s_y = $urandom;
    if (ph == 0 && dq_x.size() > 0) begin
      s_valid = 1'b1;
      s_x = dq_x[0];
      s_y = dq_y[0];
    end
    buf_addr = sweep ? 2'(cyc) : 2'($urandom_range(0, 3));
    m_ready = (int'($urandom_range(0, 99)) < p_ready);
    if (ph == 3 && rq.size() > 0) m_ready = (rq[0] != 0);
    fit_done = (ph == 2) ? (wcnt == done_at) : (int'($urandom_range(0, 99)) < p_spur);
  endtask

  task automatic compare();
    chk("s_ready", s_ready, ph == 0);
    chk("fit_start", fit_start, ph == 1);
    chk("m_valid", m_valid, ph == 3);
    chk("m_idx", m_idx, (ph == 3) ? midx : 0);
    chk("fit_coef_idx", fit_coef_idx, (ph == 3) ? midx : 0);
    chk("m_last", m_last, ph == 3 && midx == DEGREE);
    chk("err_timeout", err_timeout, merr);
    chk("frame_count", frame_count, mfc);
    if (ph == 3) chk("m_coef", m_coef, coef_mem[midx]);
    if (ph != 0) begin
      chk("buf_x", buf_x, mx[buf_addr]);
      chk("buf_y", buf_y, my[buf_addr]);
    end
    if (fit_start) begin
      n_start++;
      t_start = cyc;
    end
    if (err_timeout && !prev_err) t_err = cyc;
    prev_err = err_timeout;
    if (m_valid) n_mvalid++;
    if (m_valid && m_ready) begin
      o_idx.push_back(int'(m_idx));
      o_coef.push_back(m_coef);
      o_last.push_back(m_last);
    end
    if (ph == 2) begin
      bx[buf_addr] = buf_x;
      by[buf_addr] = buf_y;
    end
  endtask

  task automatic model_update();
    frame_end = 1'b0;
    case (ph)
      0: if (s_valid) begin
        mx[nsamp] = s_x;
        my[nsamp] = s_y;
        merr = 1'b0;
        nsamp++;
        if (dq_x.size() > 0) begin
          void'(dq_x.pop_front());
          void'(dq_y.pop_front());
        end
        if (nsamp == N) begin
          nsamp = 0;
          ph = 1;
        end
      end
      1: begin
        ph = 2;
        wcnt = 0;
      end
      2: if (fit_done) begin
        ph = 3;
        midx = 0;
      end else if (wcnt == TIMEOUT - 1) begin
        merr = 1'b1;
        ph = 0;
        frame_end = 1'b1;
      end else begin
        wcnt++;
      end
      default: begin
        if (rq.size() > 0) void'(rq.pop_front());
        if (m_ready) begin
          if (midx == DEGREE) begin
            mfc++;
            ph = 0;
            midx = 0;
            frame_end = 1'b1;
          end else begin
            midx++;
          end
        end
      end
    endcase
  endtask

  task automatic cycle();
    drive();
    #1;
    compare();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_frame(input string name);
    int n = 0;
    frame_end = 1'b0;
    while (!frame_end && n < 300) begin
      cycle();
      n++;
    end
    checks++;
    if (!frame_end) begin
      errors++;
      $display("FAIL %s: frame did not end within 300 cycles (model phase %0d)", name, ph);
    end
  endtask

  task automatic clear_obs();
    o_idx.delete();
    o_coef.delete();
    o_last.delete();
    n_start = 0;
    n_mvalid = 0;
    t_err = -1;
  endtask

  task automatic async_reset(input string tag);
    s_valid = 1'b0;
    m_ready = 1'b0;
    fit_done = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_fit_start"}, fit_start, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_idx"}, m_idx, 0);
    chk({tag, "_fit_coef_idx"}, fit_coef_idx, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    ph = 0; nsamp = 0; wcnt = 0; midx = 0; merr = 1'b0; mfc = 16'd0; prev_err = 1'b0;
    dq_x.delete(); dq_y.delete(); rq.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; fit_done = 1'b0; buf_addr = '0; m_ready = 1'b0;
    coef_mem = '{32'd0, 32'd0, 32'd0, 32'd0};
    cyc = 0; sweep = 1'b0; p_spur = 0;
    ph = 0; nsamp = 0; wcnt = 0; midx = 0; merr = 1'b0; mfc = 16'd0; prev_err = 1'b0;
    @(negedge clk);
    async_reset("init");

    // basic frame with hand-known data and a quadratic whose coefficients are all one
    clear_obs();
    p_valid = 0; p_ready = 100; done_at = 4; sweep = 1'b1;
    coef_mem = '{32'd1, 32'd1, 32'd1, 32'd0};
    dq_x = '{32'd0, 32'd1, 32'd2, 32'd3};
    dq_y = '{32'd1, 32'd3, 32'd7, 32'd13};
    yexp = '{32'd1, 32'd3, 32'd7, 32'd13};
    run_frame("basic");
    sweep = 1'b0;
    chk("basic_start_pulses", n_start, 1);
    chk("basic_coef_count", o_idx.size(), 3);
    for (int i = 0; i < 3 && i < o_idx.size(); i++) begin
      chk("basic_out_idx", o_idx[i], i);
      chk("basic_out_coef", o_coef[i], 1);
      chk("basic_out_last", o_last[i], i == 2);
    end
    chk("basic_frame_count", frame_count, 1);
    for (int i = 0; i < 4; i++) begin
      chk("basic_buf_x", bx[i], i);
      chk("basic_buf_y", by[i], yexp[i]);
    end

    // backpressure with samples offered throughout the engine run and drain
    clear_obs();
    p_valid = 100; p_ready = 100; done_at = 2; p_spur = 10;
    for (int i = 0; i < 4; i++) coef_mem[i] = $urandom;
    rq = '{1, 0, 0, 1};
    run_frame("backpressure");
    chk("bp_coef_count", o_idx.size(), 3);
    chk("bp_valid_cycles", n_mvalid, 5);

    // timeout: the engine never finishes
    clear_obs();
    done_at = -1;
    run_frame("timeout");
    cycle();
    chk("timeout_latency", t_err - t_start, TIMEOUT + 1);
    chk("timeout_no_valid", n_mvalid, 0);
    chk("timeout_err_seen", prev_err, 1);
    cycle();
    chk("timeout_err_cleared", err_timeout, 0);

    // done on the expiry cycle wins
    clear_obs();
    done_at = TIMEOUT - 1;
    for (int i = 0; i < 4; i++) coef_mem[i] = $urandom;
    run_frame("collision");
    chk("collision_coef_count", o_idx.size(), 3);
    chk("collision_err", err_timeout, 0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      p_valid = $urandom_range(30, 100);
      p_ready = $urandom_range(30, 100);
      done_at = int'($urandom_range(0, 9)) - 1;
      for (int i = 0; i < 4; i++) coef_mem[i] = $urandom;
      run_frame("random");
    end

    // reset after two samples, then mid-drain, then a clean frame
    p_valid = 100; p_ready = 100; done_at = 3; p_spur = 0;
    n = 0;
    while (!(ph == 0 && nsamp == 2) && n < 50) begin cycle(); n++; end
    async_reset("rst_fill");
    n = 0;
    while (!(ph == 3 && midx == 2) && n < 100) begin cycle(); n++; end
    checks++;
    if (!(ph == 3 && midx == 2)) begin
      errors++;
      $display("FAIL rst_drain_reach: drain idx 2 not reached (phase %0d)", ph);
    end
    async_reset("rst_drain");
    run_frame("post_reset");
    chk("post_reset_frame_count", frame_count, 1);

    // frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    mfc = 16'hFFFF;
    run_frame("wrap");
    chk("wrap_frame_count", frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_fit_sequencer.md
# poly_fit_sequencer

Sequencer for the polynomial-fit engine used to derive Farrow filter coefficients. It collects a frame of N (x, y) sample pairs from a valid/ready stream into a local buffer and starts the fit engine. It serves the buffer to the engine while the engine runs, then streams the DEGREE+1 resulting coefficients out on a valid/ready port. It guards the engine run with a timeout and reports frames and errors.

## Interface
- N, 10, samples per frame (≥ 2)
- DEGREE, 5, polynomial degree; COEFS = DEGREE+1 (COEFS ≤ N)
- W, 32, sample and coefficient width (two's complement)
- TIMEOUT, 4096, maximum cycles spent in WAIT before abort (≥ 1)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_x  in  W  sample abscissa
- s_y  in  W  sample ordinate
- fit_start  out  1  one-cycle start pulse to the engine
- fit_done  in  1  engine finished (single-cycle pulse)
- buf_addr  in  $clog2(N)  engine read address into the buffer
- buf_x  out  W  buffer x at buf_addr (combinational read)
- buf_y  out  W  buffer y at buf_addr (combinational read)
- fit_coef_idx  out  $clog2(COEFS)  coefficient index presented to the engine
- fit_coef  in  W  engine coefficient at fit_coef_idx (combinational)
- m_valid  out  1  coefficient output valid
- m_ready  in  1  coefficient output ready
- m_coef  out  W  coefficient value
- m_idx  out  $clog2(COEFS)  coefficient index; 0 is the highest power
- m_last  out  1  high with idx DEGREE
- err_timeout  out  1  sticky; set on abort, cleared by the first sample accepted afterwards
- frame_count  out  16  completed frames (last coefficient accepted); wraps from 0xFFFF to 0

## Operation
- States: IDLE, FILL, START, WAIT, DRAIN.
- IDLE: s_ready=1. An accepted sample is written to buf[0], wr_ptr=1, and the FSM moves to FILL.
- FILL: s_ready=1. Each accepted sample is written to buf[wr_ptr] and wr_ptr increments. On acceptance of sample N-1, the FSM moves to START.
- START: fit_start=1 for exactly one cycle. The timeout counter clears. The FSM moves to WAIT.
- WAIT: the counter increments each cycle.
  - fit_done=1 → DRAIN with idx=0.
  - Counter reaches TIMEOUT-1 without fit_done → set err_timeout and go to IDLE.
  - fit_done in the same cycle as expiry: done wins and no error is raised.
- DRAIN: fit_coef_idx=idx; m_valid=1; m_coef=fit_coef; m_idx=idx; m_last=(idx==DEGREE).
  - On m_valid&&m_ready, idx increments.
  - On the last handshake, frame_count increments and the FSM moves to IDLE.
- s_ready=0 in START, WAIT and DRAIN. The buffer is frozen from START until IDLE, so the engine reads stable data.
- fit_done outside WAIT is ignored.
- err_timeout does not block operation; a new frame may start immediately after an abort.
- Reset, asserted at any time including mid-frame or mid-drain, forces every output and all state to the reset values below. The partial frame is discarded. Buffer contents are don't-care after reset.

## Timing
- Reset values:
  - s_ready=1 (state IDLE)
  - fit_start=0, m_valid=0, m_last=0, m_idx=0, fit_coef_idx=0
  - err_timeout=0, frame_count=0
  - buf_x/buf_y undefined
- Throughput: one sample per cycle in IDLE/FILL. One coefficient per cycle in DRAIN while m_ready=1.
- Last sample accepted at cycle t → fit_start high at t+1, s_ready low from t+1.
- fit_done at cycle d → m_valid high at d+1 with m_idx=0.
- Last coefficient handshake at cycle e → s_ready high at e+1 and frame_count updated at e+1.
- Abort: START at cycle s → err_timeout high and s_ready high at s+TIMEOUT+1.
- Coefficient stream, while m_valid=1 and m_ready=0: m_coef, m_idx and m_last hold stable.
  - This requires the engine to hold fit_coef constant for a constant index until the next fit_start.
- Minimum frame turnaround with fit_done latency L after fit_start (no stalls): N + 1 + L + COEFS cycles.

## Test plan
Configuration for all scenarios: N=4, DEGREE=2, TIMEOUT=8, W=32.
- Basic frame:
  - Stimulus: push x=0,1,2,3 with y=1,3,7,13. The engine model returns coefs [1,1,1] with fit_done 5 cycles after fit_start.
  - Response: a single fit_start pulse; buf reads match the pushed samples; out (idx,coef) = (0,1),(1,1),(2,1) with m_last on idx 2; frame_count=1.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1 during DRAIN; s_valid is driven during WAIT and DRAIN.
  - Response: outputs hold while stalled; exactly 3 coefficients are emitted; s_ready stays 0 until after m_last is accepted.
- Timeout:
  - Stimulus: the engine never asserts done.
  - Response: err_timeout rises 9 cycles after fit_start; s_ready=1; m_valid never asserts. The next accepted sample clears err_timeout.
- Done/expiry collision:
  - Stimulus: fit_done asserted exactly at counter=7.
  - Response: DRAIN is entered and err_timeout stays 0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously after 2 samples, and again after the idx-1 coefficient has been accepted.
  - Response: all outputs return to their reset values immediately. After release, a full 4-sample frame completes normally and frame_count counts only post-reset frames.
- frame_count wrap:
  - Stimulus: force the counter to 0xFFFF, then complete one frame.
  - Response: frame_count=0.
